// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller and its fetch queue.
package if_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundles the instruction-memory, redirect and ID-stage signals of the fetch controller.
interface if_fetch_ctrl_if;
  import if_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_fetch_ctrl_queue.sv
// Circular fetch queue of {pc, instr} entries; flush wins over push and pop.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign head    = empty ? '0 : mem[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop_ok)  head_ptr <= head_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues sequential fetches, buffers responses, handles redirects.
// Optional misaligned-redirect fault checking is enabled by defining IF_FETCH_ALIGN_CHK_EN.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_ctrl_if.master    bus
`ifdef IF_FETCH_ALIGN_CHK_EN
  ,
  output logic               fetch_fault
`endif
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [1:0]       ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]       ST_REQ   = 2'(REQ);
  localparam logic [1:0]       ST_DRAIN = 2'(DRAIN);

  logic [1:0]       state, state_next;
  logic             req_q, req_next;
  logic [31:0]      addr_q, addr_next;
  logic [31:0]      fetch_pc, pc_next;
  logic [31:0]      redirect_tgt;
  logic [31:0]      pc_src;
  logic             ack_fire;
  logic             push, pop, flush;
  logic [CNT_W-1:0] q_count, count_next;
  logic             q_full, q_empty;
  logic             fault_next;
  logic             issue_ok;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign redirect_tgt = bus.redirect_pc & ~32'h3;
  assign pc_src       = bus.redirect_valid ? redirect_tgt : fetch_pc;
  assign ack_fire     = req_q & bus.imem_ack;
  assign flush        = bus.redirect_valid;
  assign push         = (state == ST_REQ) & ack_fire & ~bus.redirect_valid & ~q_full;
  assign pop          = ~q_empty & bus.id_ready;
  assign push_entry   = {addr_q, bus.imem_rdata};
  assign count_next   = flush ? '0 : (q_count + CNT_W'(push) - CNT_W'(pop));
  assign issue_ok     = (count_next < DEPTH_C) & ~fault_next;

  if_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = ~q_empty;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = head.pc;

`ifdef IF_FETCH_ALIGN_CHK_EN
  logic fault_q;

  // The fault tracks the alignment of the most recent redirect target.
  always_comb begin
    fault_next = fault_q;
    if (bus.redirect_valid) fault_next = (bus.redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_next;
  end

  assign fetch_fault = fault_q;
`else
  assign fault_next = 1'b0;
`endif

  // An issued request keeps req/addr stable until acked; redirects never withdraw it.
  always_comb begin
    state_next = state;
    req_next   = req_q;
    addr_next  = addr_q;
    pc_next    = fetch_pc;
    case (state)
      ST_IDLE: begin
        if (bus.redirect_valid) pc_next = redirect_tgt;
        if (issue_ok) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
          addr_next  = pc_src;
        end
      end
      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_next = redirect_tgt;
          if (ack_fire) begin
            state_next = ST_IDLE;
            req_next   = 1'b0;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (ack_fire) begin
          pc_next = addr_q + PC_INC;
          if (issue_ok) begin
            addr_next = addr_q + PC_INC;
          end else begin
            state_next = ST_IDLE;
            req_next   = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) pc_next = redirect_tgt;
        if (ack_fire) begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      req_q    <= req_next;
      addr_q   <= addr_next;
      fetch_pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized stream check.
// Also builds with IF_FETCH_ALIGN_CHK_EN defined to cover the fault path.
module tb_if_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl_if bus();

`ifdef IF_FETCH_ALIGN_CHK_EN
  logic fetch_fault;
`endif

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_FETCH_ALIGN_CHK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc} !== 98'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got req=%b addr=%h v=%b instr=%h pc=%h, expected all zero",
               bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
    end
`ifdef IF_FETCH_ALIGN_CHK_EN
    tests_run++;
    if (fetch_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fault: got %b, expected 0", fetch_fault);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL first_req: got req=%b addr=%h, expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'h0);
    tick();
    // Reset lands mid-request; outputs must clear without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc} !== 66'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got req=%b addr=%h v=%b pc=%h, expected all zero",
               bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc);
    end
    tick();
    tests_run++;
    if ({bus.imem_req, bus.id_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL ack_in_reset: got req=%b v=%b, expected 0 0", bus.imem_req, bus.id_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    do_reset();
    bus.imem_ack = 1'b1;
    bus.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_addr = 32'(k) * 32'd4;
      tests_run++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_addr}) begin
        tests_failed++;
        $display("[TB] FAIL seq_addr[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                 k, bus.imem_req, bus.imem_addr, exp_addr);
      end
      if (k > 0) begin
        tests_run++;
        if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, exp_addr - 32'd4, mem_word(exp_addr - 32'd4)}) begin
          tests_failed++;
          $display("[TB] FAIL seq_id[%0d]: got v=%b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                   k, bus.id_valid, bus.id_pc, bus.id_instr, exp_addr - 32'd4, mem_word(exp_addr - 32'd4));
        end
      end
      bus.imem_rdata = mem_word(bus.imem_addr);
    end
  endtask

  // Fills the queue with zero-wait memory and id_ready low, then releases one pop.
  task automatic fill_and_pop_one();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.imem_rdata = mem_word(bus.imem_addr);
    end
    tick();
    tests_run++;
    if ({bus.imem_req, bus.id_valid, bus.id_pc} !== {1'b0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL full_hold: got req=%b v=%b pc=%h, expected req=0 v=1 pc=0",
               bus.imem_req, bus.id_valid, bus.id_pc);
    end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_pc, bus.id_instr} !== {1'b1, 32'h8, 32'h4, mem_word(32'h4)}) begin
      tests_failed++;
      $display("[TB] FAIL full_resume: got req=%b addr=%h pc=%h instr=%h, expected req=1 addr=8 pc=4 instr=%h",
               bus.imem_req, bus.imem_addr, bus.id_pc, bus.id_instr, mem_word(32'h4));
    end
  endtask

  task automatic test_full_queue();
    fill_and_pop_one();
  endtask

  task automatic test_redirect_drain();
    fill_and_pop_one();
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 32'h8, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL drain_hold: got req=%b addr=%h v=%b, expected req=1 addr=8 v=0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.id_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL drain_discard: got req=%b v=%b, expected 0 0", bus.imem_req, bus.id_valid);
    end
    tick();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
      tests_failed++;
      $display("[TB] FAIL drain_next: got req=%b addr=%h, expected req=1 addr=100", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    tick();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'h0);
    tick();
    bus.imem_rdata = mem_word(32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.id_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL redir_ack_drop: got req=%b v=%b, expected 0 0", bus.imem_req, bus.id_valid);
    end
    tick();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
      tests_failed++;
      $display("[TB] FAIL redir_ack_next: got req=%b addr=%h, expected req=1 addr=200", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'h200);
    tick();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      tests_failed++;
      $display("[TB] FAIL redir_ack_head: got v=%b pc=%h instr=%h, expected v=1 pc=200", bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    bus.imem_ack = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b0;
    tick();
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_top: got req=%b addr=%h, expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    bus.imem_ack = 1'b0;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_pc} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_next: got req=%b addr=%h pc=%h, expected req=1 addr=0 pc=fffffffc",
               bus.imem_req, bus.imem_addr, bus.id_pc);
    end
  endtask

  task automatic test_align();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.imem_rdata = mem_word(bus.imem_addr);
    end
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef IF_FETCH_ALIGN_CHK_EN
    tick();
    tick();
    tests_run++;
    if ({fetch_fault, bus.imem_req, bus.id_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL align_fault: got fault=%b req=%b v=%b, expected 1 0 0", fetch_fault, bus.imem_req, bus.id_valid);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    tests_run++;
    if ({fetch_fault, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
      tests_failed++;
      $display("[TB] FAIL align_resume: got fault=%b req=%b addr=%h, expected 0 1 300", fetch_fault, bus.imem_req, bus.imem_addr);
    end
`else
    tests_run++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 32'h100, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL align_clear: got req=%b addr=%h v=%b, expected req=1 addr=100 v=0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
`endif
  endtask

  // Reference: ID must see an unbroken +4 stream of mem_word(pc), restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, tgt, held_addr;
    logic        pending;
    int          pops;
    do_reset();
    exp_pc = 32'h0;
    held_addr = 32'h0;
    pending = 1'b0;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (pending) begin
        tests_run++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, held_addr}) begin
          tests_failed++;
          $display("[TB] FAIL rand_stable[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                   i, bus.imem_req, bus.imem_addr, held_addr);
        end
      end
      if (!bus.id_valid) begin
        tests_run++;
        if ({bus.id_pc, bus.id_instr} !== 64'h0) begin
          tests_failed++;
          $display("[TB] FAIL rand_idle_zero[%0d]: got pc=%h instr=%h, expected 0 0", i, bus.id_pc, bus.id_instr);
        end
      end
      bus.id_ready = ($urandom_range(3) != 0);
      bus.imem_ack = ($urandom_range(2) != 0);
      bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : $urandom;
      bus.redirect_valid = ($urandom_range(19) == 0);
      tgt = $urandom;
`ifdef IF_FETCH_ALIGN_CHK_EN
      tgt = tgt & ~32'h3;
`endif
      bus.redirect_pc = tgt;
      if (bus.redirect_valid) bus.id_ready = 1'b0;
      if (bus.id_valid && bus.id_ready) begin
        tests_run++;
        if ({bus.id_pc, bus.id_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          tests_failed++;
          $display("[TB] FAIL rand_stream[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h",
                   i, bus.id_pc, bus.id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (bus.redirect_valid) exp_pc = tgt & ~32'h3;
      pending = bus.imem_req && !bus.imem_ack;
      held_addr = bus.imem_addr;
    end
    idle_inputs();
    tests_run++;
    if (pops < 200) begin
      tests_failed++;
      $display("[TB] FAIL rand_progress: got %0d pops, expected at least 200", pops);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_full_queue();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
